// File: rtl/instr_fetch_unit.sv
// Fetch stage of the multi-cycle CPU.
// Owns the fetch PC, issues reads to the big-endian instruction memory, holds
// each read for MEM_LATENCY cycles, latches the word into IR and presents it
// to decode with a valid/ready handshake. Handles redirect (flush), stall,
// halt-opcode stop and misalignment trap.
//
// Ports:
//   CLK, RST          clock (rising edge), async active-low reset
//   PCWre             fetch enable (0 = no new request starts)
//   Redirect/RedirectPC  branch/jump flush and target
//   InstrAddr         memory byte address (= fetch PC)
//   InstrMemRW        registered memory read enable
//   InstrData         word returned by memory
//   IR/IRValid/IRReady  instruction register and decode handshake
//   CurPC/CurPC4      address of IR and that address + 4 (combinational)
//   Halted/Misaligned sticky stop causes
module instr_fetch_unit #(
  parameter logic [31:0] PC_RESET    = 32'h0000_0000,
  parameter int unsigned MEM_LATENCY = 1,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PCWre,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic [31:0] InstrAddr,
  output logic        InstrMemRW,
  input  logic [31:0] InstrData,
  output logic [31:0] IR,
  output logic        IRValid,
  input  logic        IRReady,
  output logic [31:0] CurPC,
  output logic [31:0] CurPC4,
  output logic        Halted,
  output logic        Misaligned
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned XLEN  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    STOP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   ir_q, ir_d;
  logic [XLEN-1:0]   cur_q, cur_d;
  logic              valid_q, valid_d;
  logic              rw_q, rw_d;
  logic              halt_q, halt_d;
  logic              mis_q, mis_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              try_start;

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      pc_q    <= PC_RESET;
      ir_q    <= '0;
      cur_q   <= '0;
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      halt_q  <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cur_q   <= cur_d;
      valid_q <= valid_d;
      rw_q    <= rw_d;
      halt_q  <= halt_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and next-register logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    cur_d     = cur_q;
    valid_d   = valid_q;
    rw_d      = rw_q;
    halt_d    = halt_q;
    mis_d     = mis_q;
    cnt_d     = cnt_q;
    try_start = 1'b0;

    // Redirect outranks handshake and read completion; STOP ignores it
    if (Redirect && (state_q != STOP)) begin
      pc_d    = RedirectPC;
      valid_d = 1'b0;
      rw_d    = 1'b0;
      cnt_d   = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: try_start = PCWre;
        REQ: begin
          if (cnt_q == '0) begin
            ir_d    = InstrData;
            cur_d   = pc_q;
            pc_d    = pc_q + 32'd4;
            valid_d = 1'b1;
            rw_d    = 1'b0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        HOLD: begin
          if (IRReady) begin
            valid_d = 1'b0;
            if (ir_q[31:26] == HALT_OPCODE) begin
              halt_d  = 1'b1;
              state_d = STOP;
            end else if (PCWre) begin
              try_start = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        STOP: begin
          rw_d    = 1'b0;
          valid_d = 1'b0;
        end
      endcase
    end

    // Request start shared by IDLE and back-to-back accept in HOLD
    if (try_start) begin
      if (pc_q[1:0] != 2'b00) begin
        mis_d   = 1'b1;
        state_d = STOP;
      end else begin
        rw_d    = 1'b1;
        cnt_d   = CNT_W'(MEM_LATENCY - 1);
        state_d = REQ;
      end
    end
  end

  assign InstrAddr  = pc_q;
  assign InstrMemRW = rw_q;
  assign IR         = ir_q;
  assign IRValid    = valid_q;
  assign CurPC      = cur_q;
  assign CurPC4     = cur_q + 32'd4;
  assign Halted     = halt_q;
  assign Misaligned = mis_q;

endmodule
